// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit processor: opcode decode, ALU/datapath
// strobes, stored Z/N/C flag register and branch condition evaluation.
module multicycle_control_unit #(
    parameter int OP_W    = 4,
    parameter int STATE_W = 4
) (
    input  logic               input_CLK,
    input  logic               input_Reset_n,
    input  logic [15:0]        input_Instr,
    input  logic               input_Zero,
    input  logic               input_Negative,
    input  logic               input_Carry,
    input  logic               input_MemReady,
    output logic [OP_W-1:0]    output_ALUOp,
    output logic               output_ALUSrcA,
    output logic [1:0]         output_ALUSrcB,
    output logic               output_PCSource,
    output logic               output_PCWrite,
    output logic               output_IRWrite,
    output logic               output_IorD,
    output logic               output_MemRead,
    output logic               output_MemWrite,
    output logic               output_RegWrite,
    output logic               output_MemToReg,
    output logic               output_FlagZ,
    output logic               output_FlagN,
    output logic               output_FlagC,
    output logic [STATE_W-1:0] output_State,
    output logic               output_Halt
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = STATE_W'(0),
        S_DECODE = STATE_W'(1),
        S_EXEC_R = STATE_W'(2),
        S_EXEC_I = STATE_W'(3),
        S_ADDR   = STATE_W'(4),
        S_MEM_RD = STATE_W'(5),
        S_MEM_WB = STATE_W'(6),
        S_MEM_WR = STATE_W'(7),
        S_ALU_WB = STATE_W'(8),
        S_BRANCH = STATE_W'(9),
        S_HALT   = STATE_W'(10)
    } state_t;

    localparam logic [OP_W-1:0] OP_RMAX = OP_W'(9);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_BZ   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_BN   = OP_W'(14);

    state_t          state;
    logic            flag_z;
    logic            flag_n;
    logic            flag_c;
    logic [OP_W-1:0] opcode;
    logic            instr_unused;

    assign opcode       = input_Instr[15 -: OP_W];
    // Immediate field is consumed by the datapath's sign extender, not here.
    assign instr_unused = ^input_Instr[15-OP_W:0];

    always_ff @(posedge input_CLK or negedge input_Reset_n) begin
        if (!input_Reset_n) begin
            state  <= S_FETCH;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (input_MemReady) state <= S_DECODE;
                end
                S_DECODE: begin
                    if (opcode <= OP_RMAX)                       state <= S_EXEC_R;
                    else if (opcode == OP_ADDI)                  state <= S_EXEC_I;
                    else if (opcode == OP_LW || opcode == OP_SW) state <= S_ADDR;
                    else if (opcode == OP_BZ || opcode == OP_BN) state <= S_BRANCH;
                    else                                         state <= S_HALT;
                end
                S_EXEC_R, S_EXEC_I: begin
                    flag_z <= input_Zero;
                    flag_n <= input_Negative;
                    flag_c <= input_Carry;
                    state  <= S_ALU_WB;
                end
                S_ALU_WB: state <= S_FETCH;
                S_ADDR:   state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (input_MemReady) state <= S_MEM_WB;
                end
                S_MEM_WB: state <= S_FETCH;
                S_MEM_WR: begin
                    if (input_MemReady) state <= S_FETCH;
                end
                S_BRANCH: state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        output_ALUOp    = '0;
        output_ALUSrcA  = 1'b0;
        output_ALUSrcB  = 2'b00;
        output_PCSource = 1'b0;
        output_PCWrite  = 1'b0;
        output_IRWrite  = 1'b0;
        output_IorD     = 1'b0;
        output_MemRead  = 1'b0;
        output_MemWrite = 1'b0;
        output_RegWrite = 1'b0;
        output_MemToReg = 1'b0;
        output_Halt     = 1'b0;
        case (state)
            S_FETCH: begin
                output_MemRead = 1'b1;
                output_ALUSrcB = 2'b01;
                output_IRWrite = input_MemReady;
                output_PCWrite = input_MemReady;
            end
            S_DECODE: begin
                output_ALUSrcB = 2'b10;
            end
            S_EXEC_R: begin
                output_ALUSrcA = 1'b1;
                output_ALUOp   = opcode;
            end
            S_EXEC_I, S_ADDR: begin
                output_ALUSrcA = 1'b1;
                output_ALUSrcB = 2'b10;
            end
            S_ALU_WB: begin
                output_RegWrite = 1'b1;
            end
            S_MEM_RD: begin
                output_MemRead = 1'b1;
                output_IorD    = 1'b1;
            end
            S_MEM_WB: begin
                output_RegWrite = 1'b1;
                output_MemToReg = 1'b1;
            end
            S_MEM_WR: begin
                output_MemWrite = 1'b1;
                output_IorD     = 1'b1;
            end
            S_BRANCH: begin
                output_PCSource = 1'b1;
                output_PCWrite  = ((opcode == OP_BZ) && flag_z) ||
                                  ((opcode == OP_BN) && flag_n);
            end
            S_HALT: begin
                output_Halt = 1'b1;
            end
            default: ;
        endcase
        // Reset is asynchronous; strobes must drop in the same instant, not at the next edge.
        if (!input_Reset_n) begin
            output_PCWrite  = 1'b0;
            output_IRWrite  = 1'b0;
            output_MemRead  = 1'b0;
            output_MemWrite = 1'b0;
            output_RegWrite = 1'b0;
            output_Halt     = 1'b0;
        end
    end

    assign output_FlagZ = flag_z;
    assign output_FlagN = flag_n;
    assign output_FlagC = flag_c;
    assign output_State = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: an instruction-level model queues the expected per-cycle
// control outputs; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        zero, neg, carry, ready;

    logic [3:0]  alu_op;
    logic        src_a;
    logic [1:0]  src_b;
    logic        pc_source, pc_write, ir_write, i_or_d;
    logic        mem_read, mem_write, reg_write, mem_to_reg;
    logic        flag_z, flag_n, flag_c, halt;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_control_unit #(.OP_W(4), .STATE_W(4)) dut (
        .input_CLK      (clk),
        .input_Reset_n  (rst_n),
        .input_Instr    (instr),
        .input_Zero     (zero),
        .input_Negative (neg),
        .input_Carry    (carry),
        .input_MemReady (ready),
        .output_ALUOp   (alu_op),
        .output_ALUSrcA (src_a),
        .output_ALUSrcB (src_b),
        .output_PCSource(pc_source),
        .output_PCWrite (pc_write),
        .output_IRWrite (ir_write),
        .output_IorD    (i_or_d),
        .output_MemRead (mem_read),
        .output_MemWrite(mem_write),
        .output_RegWrite(reg_write),
        .output_MemToReg(mem_to_reg),
        .output_FlagZ   (flag_z),
        .output_FlagN   (flag_n),
        .output_FlagC   (flag_c),
        .output_State   (state),
        .output_Halt    (halt)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       pcsrc, pcw, irw, iord, mr, mw, rw, m2r;
        logic       fz, fn, fc, hlt;
    } obs_t;

    obs_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic mz = 1'b0, mn = 1'b0, mc = 1'b0;

    function automatic obs_t actual();
        obs_t o;
        o.st = state;   o.aluop = alu_op; o.srca = src_a; o.srcb = src_b;
        o.pcsrc = pc_source; o.pcw = pc_write; o.irw = ir_write; o.iord = i_or_d;
        o.mr = mem_read; o.mw = mem_write; o.rw = reg_write; o.m2r = mem_to_reg;
        o.fz = flag_z; o.fn = flag_n; o.fc = flag_c; o.hlt = halt;
        return o;
    endfunction

    function automatic void check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h (state got %0d exp %0d)",
                     name, $time, got, exp, got.st, exp.st);
        end
    endfunction

    function automatic obs_t base(input logic [3:0] st);
        obs_t e = '0;
        e.st = st; e.fz = mz; e.fn = mn; e.fc = mc;
        return e;
    endfunction

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("cycle", actual(), e);
            end
        end
    end

    // Called at posedge+1: queue expectation, drive inputs, advance one clock.
    task automatic step(input obs_t e, input logic rdy, input logic z, input logic n, input logic c);
        sb.push_back(e);
        ready = rdy; zero = z; neg = n; carry = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step_r(input obs_t e, input logic rdy);
        step(e, rdy, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic fetch_decode(input logic [15:0] in, input int fst);
        obs_t e;
        instr = in;
        for (int i = 0; i < fst; i++) begin
            e = base(4'd0); e.srcb = 2'b01; e.mr = 1'b1;
            step_r(e, 1'b0);
        end
        e = base(4'd0); e.srcb = 2'b01; e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        step_r(e, 1'b1);
        e = base(4'd1); e.srcb = 2'b10;
        step_r(e, 1'($urandom));
    endtask

    task automatic run_instr(input logic [15:0] in, input int fst, input int mst,
                             input logic z, input logic n, input logic c);
        obs_t e;
        logic [3:0] op;
        op = in[15:12];
        fetch_decode(in, fst);
        if (op <= 4'd10) begin
            e = base(op <= 4'd9 ? 4'd2 : 4'd3);
            e.srca  = 1'b1;
            e.srcb  = (op <= 4'd9) ? 2'b00 : 2'b10;
            e.aluop = (op <= 4'd9) ? op : 4'd0;
            step(e, 1'($urandom), z, n, c);
            mz = z; mn = n; mc = c;
            e = base(4'd8); e.rw = 1'b1;
            step_r(e, 1'($urandom));
        end else if (op == 4'd11 || op == 4'd12) begin
            e = base(4'd4); e.srca = 1'b1; e.srcb = 2'b10;
            step_r(e, 1'($urandom));
            e = base(op == 4'd11 ? 4'd5 : 4'd7);
            e.iord = 1'b1;
            if (op == 4'd11) e.mr = 1'b1; else e.mw = 1'b1;
            for (int i = 0; i < mst; i++) step_r(e, 1'b0);
            step_r(e, 1'b1);
            if (op == 4'd11) begin
                e = base(4'd6); e.rw = 1'b1; e.m2r = 1'b1;
                step_r(e, 1'($urandom));
            end
        end else if (op == 4'd13 || op == 4'd14) begin
            e = base(4'd9); e.pcsrc = 1'b1;
            e.pcw = (op == 4'd13) ? mz : mn;
            step_r(e, 1'($urandom));
        end else begin
            e = base(4'd10); e.hlt = 1'b1;
            for (int i = 0; i < 25; i++) step_r(e, 1'($urandom));
        end
    endtask

    // Entered at posedge+1; asserts reset between edges and holds it across one edge.
    task automatic do_reset();
        obs_t e;
        #2 rst_n = 1'b0;
        #1;
        mz = 1'b0; mn = 1'b0; mc = 1'b0;
        e = base(4'd0); e.srcb = 2'b01;
        check("reset_async", actual(), e);
        @(posedge clk);
        #1;
        check("reset_hold", actual(), e);
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        obs_t e;
        rst_n = 1'b0; instr = '0; zero = 1'b0; neg = 1'b0; carry = 1'b0; ready = 1'b0;
        #3;
        e = base(4'd0); e.srcb = 2'b01;
        check("reset_initial", actual(), e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(16'h1234, 0, 0, 1'b1, 1'b0, 1'b0);
        run_instr(16'hB012, 0, 3, 1'b0, 1'b0, 1'b0);
        run_instr(16'hD0FE, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(16'h0111, 1, 0, 1'b0, 1'b1, 1'b1);
        run_instr(16'hD0FE, 0, 0, 1'b0, 1'b0, 1'b0);
        run_instr(16'hE010, 2, 0, 1'b0, 1'b0, 1'b0);
        run_instr(16'hC005, 0, 0, 1'b0, 1'b0, 1'b0);

        run_instr(16'hA0FF, 0, 0, 1'b1, 1'b1, 1'b1);
        fetch_decode(16'h2345, 0);
        ready = 1'b1; zero = 1'b0; neg = 1'b0; carry = 1'b0;
        do_reset();

        for (int k = 0; k < 60; k++) begin
            run_instr({4'($urandom_range(0, 14)), 12'($urandom)},
                      $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), 1'($urandom), 1'($urandom));
        end

        run_instr(16'hF000, 0, 0, 1'b0, 1'b0, 1'b0);
        do_reset();
        run_instr(16'h3000, 1, 0, 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d entries left exp=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle control FSM for the 16-bit processor. It decodes the instruction-register opcode and drives the ALU operation code, ALU operand selects and datapath write strobes. It also holds the architectural Zero/Negative/Carry flag register that the ALU produces, and evaluates branch conditions from it. It sits between the instruction register, memory handshake, register file and ALU.

Parameters:
OP_W, 4, opcode and ALUOp width
STATE_W, 4, width of the state encoding exported on output_State

Ports:
input_CLK  in  1  system clock; all state updates on rising edge
input_Reset_n  in  1  asynchronous, active-low reset
input_Instr  in  16  instruction register contents; opcode = input_Instr[15:12]
input_Zero  in  1  ALU zero flag, current cycle
input_Negative  in  1  ALU negative flag, current cycle
input_Carry  in  1  ALU carry flag, current cycle
input_MemReady  in  1  memory access completes this cycle
output_ALUOp  out  4  ALU operation code (0000 add … 1001 2*(A+B))
output_ALUSrcA  out  1  0 = PC, 1 = register A
output_ALUSrcB  out  2  00 = register B, 01 = constant 1, 10 = sign-extended input_Instr[7:0]
output_PCSource  out  1  0 = ALU result, 1 = ALUOut register
output_PCWrite  out  1  load PC
output_IRWrite  out  1  load instruction register
output_IorD  out  1  memory address: 0 = PC, 1 = ALUOut
output_MemRead  out  1  memory read request
output_MemWrite  out  1  memory write request
output_RegWrite  out  1  register file write
output_MemToReg  out  1  writeback data: 0 = ALUOut, 1 = memory data register
output_FlagZ / output_FlagN / output_FlagC  out  1 each  stored flag register
output_State  out  4  current state, for debug and verification
output_Halt  out  1  high while in HALT

Behaviour:
- ISA opcodes:
  - 0x0–0x9: R-type. ALUOp = opcode.
  - 0xA: ADDI.
  - 0xB: LW.
  - 0xC: SW.
  - 0xD: BZ (branch if stored Z).
  - 0xE: BN (branch if stored N).
  - 0xF: HALT.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, ALU_WB=8, BRANCH=9, HALT=10. Unused encodings go to FETCH.
- Reset (input_Reset_n=0, asynchronous):
  - State goes to FETCH and flags go to 0.
  - While reset is held, all strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) are forced to 0 and output_Halt=0.
  - Reset mid-instruction abandons the instruction; no partial writes occur after reset asserts.
- Outputs are combinational from state (Moore), except the handshake gating below. Defaults: strobes 0, ALUOp 0000, selects 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0000, PCSource=0.
  - IRWrite and PCWrite are asserted only in the cycle input_MemReady=1; that cycle transitions to DECODE.
  - Otherwise the FSM stays in FETCH and holds MemRead.
- DECODE:
  - ALUSrcA=0, ALUSrcB=10, ALUOp=0000, so branch target PC+sext(imm) lands in ALUOut.
  - Next state: 0x0–0x9 → EXEC_R; 0xA → EXEC_I; 0xB/0xC → ADDR; 0xD/0xE → BRANCH; 0xF → HALT.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=opcode. Flags capture input_Zero/Negative/Carry on the clock edge. Next → ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=0000. Flags capture. Next → ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0. Next → FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=0000. Flags are NOT updated. Next → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead=1, IorD=1. Waits for input_MemReady, then → MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1. Next → FETCH.
- MEM_WR:
  - MemWrite=1, IorD=1 while waiting.
  - On input_MemReady=1 → FETCH.
  - MemWrite stays high for exactly the waiting cycles plus the ready cycle.
- BRANCH:
  - PCSource=1; PCWrite = (opcode 0xD & FlagZ) | (opcode 0xE & FlagN).
  - Flags unchanged. Next → FETCH.
  - Branch uses the flags stored before DECODE, never the live ALU flags.
- HALT: output_Halt=1, all strobes 0. Remains in HALT until reset.
- Flags change only on the EXEC_R/EXEC_I exit edge; they hold through loads, stores, branches and stalls.
- Latency with input_MemReady tied high:
  - R-type/ADDI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Branch: 3 cycles.
- MemReady asserted in a non-memory state is ignored.

Test Plan:
- Reset: assert input_Reset_n=0 asynchronously mid-EXEC_R → output_State=0 immediately; strobes 0; flags 000. After release, FETCH issues MemRead=1.
- R-type SUB: instr 0x1xxx, ALU returns Zero=1, MemReady=1 → states 0,1,2,8,0; ALUOp=0001 in EXEC_R; RegWrite for exactly 1 cycle; FlagZ=1 afterward.
- LW with 3-cycle memory stall: instr 0xB0xx, MemReady low 3 cycles in MEM_RD → MEM_RD held 4 cycles; MemRead high throughout; single RegWrite with MemToReg=1; flags unchanged.
- Branches: FlagZ=1 then BZ (0xD0FE) → PCWrite=1, PCSource=1 in BRANCH. FlagZ=0 → PCWrite=0; 3-cycle instruction.
- SW: instr 0xC005, MemReady=1 → MemWrite=1 for exactly 1 cycle with IorD=1; RegWrite never asserted.
- HALT: instr 0xF000 → output_Halt=1 and state 10 held for ≥20 cycles with no strobes; reset returns to FETCH.
